// File: rtl/load_store_unit.sv
// Load/store unit in front of a single-ported, combinational-read DataMemory.
// Byte and halfword stores become read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  state_t      state, state_next;
  logic        we_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic        accept, req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext, merged;

  assign accept = req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_H:  req_err = req_addr[0];
      SIZE_W:  req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr >= 32'(MEM_BYTES)) req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_next = RESP;
          else if (!req_we)          state_next = LOAD;
          else if (req_size == SIZE_W) state_next = STORE_W;
          else                       state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      STORE_W: state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction from the live read word, then sign/zero extension.
  always_comb begin
    load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SIZE_B:  load_ext = {{24{signed_q & load_byte[7]}}, load_byte};
      SIZE_H:  load_ext = {{16{signed_q & load_half[15]}}, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Captured word with the addressed lane(s) replaced by the store data.
  always_comb begin
    merged = word_q;
    if (size_q == SIZE_B) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        rdata_q  <= '0;
      end
      if (state == LOAD)   rdata_q <= load_ext;
      if (state == RMW_RD) word_q  <= mem_rdata;
    end
  end

  assign req_ready  = rst_n && (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_read   = (state == LOAD) || (state == RMW_RD);
  assign mem_write  = (state == STORE_W) || (state == RMW_WR);
  assign mem_wdata  = (state == STORE_W) ? wdata_q :
                      (state == RMW_WR)  ? merged  : 32'h0;

  // we_q is kept for visibility of the accepted request; decode relies on state.
  logic unused_ok;
  assign unused_ok = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver pushes expected responses,
// a negedge monitor pops and compares them against the DUT with a behavioural DataMemory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DataMemory model: write commits at posedge, read is combinational.
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_write && mem_addr < 32'd1024) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] wdata;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int issued = 0, done = 0;
  int rd_cnt = 0, wr_cnt = 0, busy_drop = 0, last_resp_cyc = -10;
  logic [31:0] last_wdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: accumulates memory activity per transaction and scores each response.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0; busy_drop = 0;
    end else begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin wr_cnt++; last_wdata = mem_wdata; end
      if (issued > done && !busy) busy_drop++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, ".rdata"}, resp_rdata, e.rdata);
          check({e.name, ".err"}, {31'h0, resp_err}, {31'h0, e.err});
          check({e.name, ".latency"}, cyc - e.acc_cyc, e.lat);
          check({e.name, ".reads"}, rd_cnt, e.reads);
          check({e.name, ".writes"}, wr_cnt, e.writes);
          check({e.name, ".busy_held"}, busy_drop, 32'd0);
          check({e.name, ".ready_low"}, {31'h0, req_ready}, 32'd0);
          if (e.writes > 0) check({e.name, ".mem_wdata"}, last_wdata, e.wdata);
        end
        rd_cnt = 0; wr_cnt = 0; busy_drop = 0;
        last_resp_cyc = cyc;
        done++;
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input int reads, input int writes, input logic [31:0] mwdata,
                       input bit hold, input bit gap_check);
    exp_t e;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        e.name = name; e.err = err; e.rdata = rdata; e.lat = lat;
        e.reads = reads; e.writes = writes; e.wdata = mwdata; e.acc_cyc = cyc;
        sb.push_back(e);
        if (gap_check) check({name, ".accept_after_resp"}, cyc, last_resp_cyc + 1);
      end
    end
    if (!ok) begin
      check({name, ".accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      issued++;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done == issued) ok = 1'b1;
    end
    if (!ok) check({name, ".resp_timeout"}, 32'd0, 32'd1);
  endtask

  // Convenience wrapper for a single request followed by drain.
  task automatic op(input string name, input logic we, input logic [1:0] size,
                    input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic err, input logic [31:0] rdata, input int lat,
                    input int reads, input int writes, input logic [31:0] mwdata);
    issue(name, we, size, sgn, addr, wdata, err, rdata, lat, reads, writes, mwdata, 1'b0, 1'b0);
    wait_idle(name);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst.busy", {31'h0, busy}, 32'd0);
    check("rst.mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst.req_ready", {31'h0, req_ready}, 32'd1);

    //   name         we    size   sgn   addr   wdata          err  rdata         lat r w mwdata
    op("sw8",        1'b1, 2'b10, 1'b0, 32'd8,    32'h00000097, 1'b0, 32'h0,        2, 0, 1, 32'h00000097);
    op("lw8",        1'b0, 2'b10, 1'b0, 32'd8,    32'h0,        1'b0, 32'h00000097, 2, 1, 0, 32'h0);
    op("sw4",        1'b1, 2'b10, 1'b0, 32'd4,    32'h11223344, 1'b0, 32'h0,        2, 0, 1, 32'h11223344);
    op("sw12",       1'b1, 2'b10, 1'b0, 32'd12,   32'h80FF7F01, 1'b0, 32'h0,        2, 0, 1, 32'h80FF7F01);
    op("sb6",        1'b1, 2'b00, 1'b0, 32'd6,    32'h000000AB, 1'b0, 32'h0,        3, 1, 1, 32'h11AB3344);
    op("lw4",        1'b0, 2'b10, 1'b0, 32'd4,    32'h0,        1'b0, 32'h11AB3344, 2, 1, 0, 32'h0);
    op("lb14",       1'b0, 2'b00, 1'b1, 32'd14,   32'h0,        1'b0, 32'hFFFFFFFF, 2, 1, 0, 32'h0);
    op("lbu14",      1'b0, 2'b00, 1'b0, 32'd14,   32'h0,        1'b0, 32'h000000FF, 2, 1, 0, 32'h0);
    op("lh12",       1'b0, 2'b01, 1'b1, 32'd12,   32'h0,        1'b0, 32'h00007F01, 2, 1, 0, 32'h0);
    op("lh14",       1'b0, 2'b01, 1'b1, 32'd14,   32'h0,        1'b0, 32'hFFFF80FF, 2, 1, 0, 32'h0);
    op("lhu14",      1'b0, 2'b01, 1'b0, 32'd14,   32'h0,        1'b0, 32'h000080FF, 2, 1, 0, 32'h0);
    op("lb15",       1'b0, 2'b00, 1'b1, 32'd15,   32'h0,        1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h0);
    op("lbu13",      1'b0, 2'b00, 1'b0, 32'd13,   32'h0,        1'b0, 32'h0000007F, 2, 1, 0, 32'h0);
    op("sh10",       1'b1, 2'b01, 1'b0, 32'd10,   32'hFFFF1234, 1'b0, 32'h0,        3, 1, 1, 32'h12340097);
    op("lw8b",       1'b0, 2'b10, 1'b0, 32'd8,    32'h0,        1'b0, 32'h12340097, 2, 1, 0, 32'h0);
    op("sw1020",     1'b1, 2'b10, 1'b0, 32'd1020, 32'hA5A50001, 1'b0, 32'h0,        2, 0, 1, 32'hA5A50001);
    op("lw1020",     1'b0, 2'b10, 1'b0, 32'd1020, 32'h0,        1'b0, 32'hA5A50001, 2, 1, 0, 32'h0);
    op("err_lw6",    1'b0, 2'b10, 1'b0, 32'd6,    32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
    op("err_sh5",    1'b1, 2'b01, 1'b0, 32'd5,    32'h1234,     1'b1, 32'h0,        1, 0, 0, 32'h0);
    op("err_size",   1'b0, 2'b11, 1'b0, 32'd0,    32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
    op("err_lw1024", 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
    op("err_sb1024", 1'b1, 2'b00, 1'b0, 32'd1024, 32'h5A,       1'b1, 32'h0,        1, 0, 0, 32'h0);

    // Back-to-back with req_valid held high across both requests.
    issue("hs_a", 1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 1'b0, 32'h12340097, 2, 1, 0, 32'h0, 1'b1, 1'b0);
    issue("hs_b", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 1'b0, 32'h80FF7F01, 2, 1, 0, 32'h0, 1'b0, 1'b1);
    wait_idle("hs");

    // Reset asserted during RMW_WR must suppress the write.
    op("sw0", 1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFEBABE, 1'b0, 32'h0, 2, 0, 1, 32'hCAFEBABE);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) seen = 1'b1;
    end
    check("rstmid.reached_rmw_wr", {31'h0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
    check("rstmid.busy_resp", {30'h0, busy, resp_valid}, 32'd0);
    check("rstmid.mem_addr", mem_addr, 32'h0);
    check("rstmid.mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid.req_ready", {31'h0, req_ready}, 32'd1);
    op("lw0_after_rst", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 32'hCAFEBABE, 2, 1, 0, 32'h0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of DataMemory; converts CPU load/store requests into DataMemory port activity.
- Handles byte, halfword and word accesses.
  - Sub-word stores are done as read-modify-write sequences.
  - Load data is sign- or zero-extended before return.
- Checks alignment and range, and stalls the datapath through busy while a request is in flight.

Parameters:
MEM_BYTES, 1024, size of the DataMemory byte space; byte addresses >= MEM_BYTES are errors.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores and errors)
resp_err  out  1  valid with resp_valid; misaligned, out-of-range or illegal size
busy  out  1  high whenever state != IDLE
mem_addr  out  32  word-aligned byte address to DataMemory (req_addr with [1:0] = 0)
mem_read  out  1  DataMemory MemRead
mem_write  out  1  DataMemory MemWrite
mem_wdata  out  32  DataMemory WriteData
mem_rdata  in  32  DataMemory readdata (combinational from mem_addr while mem_read = 1)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; resp_valid, resp_err, busy, mem_read and mem_write = 0; mem_addr, mem_wdata and resp_rdata = 0; req_ready = 1 once rst_n is high.
- Decided DataMemory contract:
  - Write commits on the posedge where mem_write = 1.
  - Read data is valid in the same cycle mem_read = 1.
  - Memory is little-endian: byte k of a word is bits [8k+7:8k].
- Accept: request is taken on the posedge where req_valid && req_ready. All request fields are registered at that edge; inputs are ignored afterwards.
- Error check at accept:
  - size 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_BYTES.
  - On error, go to RESP with err = 1; no memory access occurs.
- FSM states: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
  - IDLE -> LOAD on an accepted load.
  - IDLE -> STORE_W on an accepted word store.
  - IDLE -> RMW_RD on an accepted byte or halfword store.
  - IDLE -> RESP on an accepted request that fails the error check.
  - LOAD: mem_read = 1; capture mem_rdata at end of cycle; -> RESP.
  - STORE_W: mem_write = 1, mem_wdata = stored wdata; -> RESP.
  - RMW_RD: mem_read = 1; capture word; -> RMW_WR.
  - RMW_WR: mem_write = 1; mem_wdata = captured word with the target lane(s) replaced:
    - byte: lane addr[1:0] gets wdata[7:0];
    - halfword: lane pair addr[1] gets wdata[15:0].
    - -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle; -> IDLE.
- mem_* outputs are decoded from registered state and registered request fields. mem_read and mem_write are never both 1. mem_addr holds the last value in IDLE, with mem_read = mem_write = 0.
- Load extraction: select lane(s) by addr, then extend per req_signed. Word loads pass through unchanged.
- Latency, accept edge to resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- No response backpressure. req_ready = 0 in every non-IDLE state, including RESP, so back-to-back throughput is one request per latency+1 cycles.
- Reset mid-operation: everything returns to the reset values immediately. In particular, if rst_n is low at the RMW_WR or STORE_W edge, no write commits.
- Address wrap: none; out-of-range is an error, never truncated.

Test Plan:
- Word store then load: store addr 8, wdata 0x00000097 -> mem_write at cycle 1 after accept, resp 2 cycles after accept, err 0. Load addr 8, size 10 -> resp_rdata 0x00000097 2 cycles after accept.
- Byte RMW: memory word at 4 = 0x11223344; store byte addr 6, wdata 0xAB -> one mem_read cycle, then mem_wdata 0x11AB3344; resp 3 cycles after accept.
- Signed/unsigned loads: word at 12 = 0x80FF7F01.
  - lb addr 14 signed -> 0xFFFFFFFF;
  - lbu addr 14 -> 0x000000FF;
  - lh addr 12 signed -> 0x00007F01;
  - lh addr 14 signed -> 0xFFFF80FF.
- Errors, each -> resp_valid with err 1 one cycle after accept, no mem_read/mem_write, resp_rdata 0:
  - word load addr 6;
  - halfword store addr 5;
  - size 11;
  - addr 1024 with MEM_BYTES = 1024.
- Handshake: hold req_valid high for two consecutive requests -> second accepted only on the cycle after RESP; busy high throughout.
- Reset during RMW_WR of a byte store to addr 0 -> memory word unchanged, all outputs 0, req_ready 1 after release.
